pipe_skew_delay: RTL

PIPE_SKEW_DELAY -- requirements
Module: pipe_skew_delay

---
 rtl/pipe_skew_pkg.sv | 22 ++
 rtl/pipe_skew_lane.sv | 63 ++++++
 rtl/pipe_skew_delay.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_skew_pkg.sv
// Shared types and helpers for the pipe_skew_delay block.
// The optional beat counter is enabled by defining PIPE_SKEW_STATS_EN.
package pipe_skew_pkg;

    typedef enum logic [1:0] {
        UNIFORM = 2'd0,
        ASC     = 2'd1,
        DESC    = 2'd2,
        RSVD    = 2'd3
    } mode_t;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Bits needed to hold a depth value in the range 0..max_depth.
    function automatic int depth_w(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

endpackage

// File: rtl/pipe_skew_lane.sv
// One data lane: a tapped shift register of data plus valid. The valid bit
// only survives up to the selected tap, so a beat that has been presented is
// dropped instead of lingering deeper in the chain. Data bits carry no reset;
// out_data is masked by the valid bit instead.
module pipe_skew_lane #(
    parameter int WIDTH = 8,
    parameter int LEN   = 11,
    parameter int TAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAP_W-1:0] tap,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [LEN-1:0]   vld;
    logic [WIDTH-1:0] dat [LEN];

    // Valid chain: flush wins over en; bits beyond the tap are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= in_valid;
            for (int j = 1; j < LEN; j++) begin
                vld[j] <= (j <= int'(tap)) ? vld[j-1] : 1'b0;
            end
        end
    end

    // Data chain advances with en only.
    always_ff @(posedge clk) begin
        if (en) begin
            dat[0] <= in_data;
            for (int j = 1; j < LEN; j++) begin
                dat[j] <= dat[j-1];
            end
        end
    end

    // Tap select with zero data whenever the selected slot is empty.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        for (int j = 0; j < LEN; j++) begin
            if (j == int'(tap)) begin
                out_valid = vld[j];
                out_data  = vld[j] ? dat[j] : '0;
            end
        end
    end

    assign busy = |vld;

endmodule

// File: rtl/pipe_skew_delay.sv
// Multi-lane programmable delay with per-lane skew. Configuration changes are
// only applied while the pipeline is empty; a request arriving with beats in
// flight is parked in PENDING until the pipeline drains or is flushed.
// Optional feature macro: PIPE_SKEW_STATS_EN adds the 32-bit beat_cnt output.
module pipe_skew_delay
    import pipe_skew_pkg::*;
#(
    parameter  int LANES     = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_DEPTH = 8,
    localparam int DEPTH_W   = depth_w(MAX_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   cfg_load,
    input  logic [DEPTH_W-1:0]     cfg_depth,
    input  logic [1:0]             cfg_mode,
    output logic                   cfg_busy,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data
`ifdef PIPE_SKEW_STATS_EN
    ,
    output logic [31:0]            beat_cnt
`endif
);

    localparam int LEN   = MAX_DEPTH + LANES - 1;
    localparam int TAP_W = depth_w(LEN);

    state_t             state, state_nxt;
    logic [DEPTH_W-1:0] act_depth, pend_depth, req_depth, apply_depth;
    mode_t              act_mode, pend_mode, req_mode, apply_mode;
    logic               apply, latch, accept, empty;
    logic [LANES-1:0]   lane_busy;

    function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [DEPTH_W-1:0] d);
        if (d == '0)
            return DEPTH_W'(1);
        else if (int'(d) > MAX_DEPTH)
            return DEPTH_W'(MAX_DEPTH);
        else
            return d;
    endfunction

    function automatic logic [TAP_W-1:0] lane_skew(input mode_t m, input int lane);
        case (m)
            ASC:     return TAP_W'(lane);
            DESC:    return TAP_W'(LANES - 1 - lane);
            default: return '0;
        endcase
    endfunction

    assign accept    = in_valid & in_ready & en;
    assign empty     = ~|lane_busy;
    assign req_depth = clamp_depth(cfg_depth);
    assign req_mode  = mode_t'(cfg_mode);

    // Next-state, config apply/latch decisions and handshake outputs.
    always_comb begin
        state_nxt   = state;
        apply       = 1'b0;
        latch       = 1'b0;
        apply_depth = cfg_load ? req_depth : pend_depth;
        apply_mode  = cfg_load ? req_mode  : pend_mode;
        in_ready    = (state == RUN);
        cfg_busy    = (state == PENDING);
        case (state)
            RUN: begin
                if (cfg_load) begin
                    if (empty && !accept) begin
                        apply = 1'b1;
                    end else begin
                        latch     = 1'b1;
                        state_nxt = PENDING;
                    end
                end
            end
            PENDING: begin
                latch = cfg_load;
                if (empty || flush) begin
                    apply     = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // State and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            act_depth  <= DEPTH_W'(1);
            act_mode   <= UNIFORM;
            pend_depth <= DEPTH_W'(1);
            pend_mode  <= UNIFORM;
        end else begin
            state <= state_nxt;
            if (apply) begin
                act_depth <= apply_depth;
                act_mode  <= apply_mode;
            end
            if (latch) begin
                pend_depth <= req_depth;
                pend_mode  <= req_mode;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [TAP_W-1:0] tap;
        assign tap = TAP_W'(act_depth) - TAP_W'(1) + lane_skew(act_mode, i);

        pipe_skew_lane #(
            .WIDTH (WIDTH),
            .LEN   (LEN),
            .TAP_W (TAP_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .flush     (flush),
            .in_valid  (accept),
            .in_data   (in_data[i*WIDTH +: WIDTH]),
            .tap       (tap),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .busy      (lane_busy[i])
        );
    end

`ifdef PIPE_SKEW_STATS_EN
    // Accepted-beat counter; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_cnt <= '0;
        else if (accept)
            beat_cnt <= beat_cnt + 32'd1;
    end
`endif

endmodule
